reg_xfer_seq: RTL and testbench

Command-driven register-transfer sequencer with an integrated 3-register, 4-bit datapath (A, B, C) on a shared source bus.
- Initiator side of the register/bus/load interface: drives the source-bus select and single-cycle load strobes from a valid/ready command stream instead of manual switch and button inputs.
- Executes MOVE, INC, DEC and a multi-cycle SWAP.
- Register contents are exported for the 7-segment display path.

---
 rtl/reg_xfer_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_reg_xfer_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_seq.sv
// reg_xfer_seq
//   Command-driven register-transfer sequencer wrapped around a 3-register
//   (A, B, C) datapath that shares one source bus. A valid/ready command
//   stream replaces manual bus-select switches and load buttons. The
//   sequencer drives the bus select and single-cycle load strobes itself.
//
//   Operations:
//     MOVE  dst <= bus(src)      (src=11 places constant zero on the bus)
//     INC   dst <= dst + 1       (wraps modulo 2^WIDTH)
//     DEC   dst <= dst - 1       (wraps modulo 2^WIDTH)
//     SWAP  A <-> B              (uses C as a temp, so C is clobbered)
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//     cmd_op/cmd_src/cmd_dst   command fields, latched on accept
//     bus_sel                  current bus source (00 A, 01 B, 10 C, 11 zero)
//     load_a/load_b/load_c     one-cycle load strobes
//     reg_a/reg_b/reg_c        register contents, for the display path
//     busy                     high in every state except IDLE
//     done                     one-cycle completion pulse
//     err                      one-cycle illegal-command pulse
//     xfer_cnt                 saturating count of load strobes
//                              (present only when XFER_COUNT_EN is defined)
//
//   Optional feature macro: XFER_COUNT_EN
//
//   All FSM outputs are registered. Each output value is computed at the
//   edge that enters the state in which it is meant to be seen. An accepted
//   command therefore shows its bus select and load strobe, or its err
//   pulse, during the EXEC cycle itself.
module reg_xfer_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_src,
  input  logic [1:0]       cmd_dst,
  output logic [1:0]       bus_sel,
  output logic             load_a,
  output logic             load_b,
  output logic             load_c,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] reg_c,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef XFER_COUNT_EN
  ,
  output logic [7:0]       xfer_cnt
`endif
);

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SW1,
    S_SW2,
    S_SW3,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic             r_illegal;
  logic             r_same;

  logic             w_accept;
  logic             w_illegal;
  logic [WIDTH-1:0] w_bus;
  logic [WIDTH-1:0] w_wdata;

  // Return the one-hot load strobe {c,b,a} for a destination code.
  // dst=11 decodes to no strobe.
  function automatic logic [2:0] f_ld(input logic [1:0] d);
    case (d)
      2'b00:   f_ld = 3'b001;
      2'b01:   f_ld = 3'b010;
      2'b10:   f_ld = 3'b100;
      default: f_ld = 3'b000;
    endcase
  endfunction

  assign w_accept  = cmd_valid && cmd_ready;
  // A SWAP only exchanges A and B, so both of its operand codes must have bit 1 clear.
  assign w_illegal = (cmd_op == OP_SWAP) ? (cmd_src[1] || cmd_dst[1])
                                         : (cmd_dst == 2'b11);

  // Shared source bus. Select 11 drives constant zero.
  always_comb begin
    w_bus = '0;
    case (bus_sel)
      SEL_A:   w_bus = reg_a;
      SEL_B:   w_bus = reg_b;
      SEL_C:   w_bus = reg_c;
      default: w_bus = '0;
    endcase
  end

  // INC/DEC place dst itself on the bus and adjust the value on the way back.
  // The SWAP states carry r_op=SWAP, so they pass the bus value through unchanged.
  always_comb begin
    w_wdata = w_bus;
    case (r_op)
      OP_INC:  w_wdata = w_bus + WIDTH'(1);
      OP_DEC:  w_wdata = w_bus - WIDTH'(1);
      default: w_wdata = w_bus;
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MOVE;
      r_illegal <= 1'b0;
      r_same    <= 1'b0;
      bus_sel   <= SEL_A;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      load_c    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      load_a <= 1'b0;
      load_b <= 1'b0;
      load_c <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_EXEC;
            r_op      <= cmd_op;
            r_illegal <= w_illegal;
            r_same    <= (cmd_src == cmd_dst);
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (w_illegal) begin
              err <= 1'b1;
            end else if (cmd_op == OP_MOVE) begin
              bus_sel                  <= cmd_src;
              {load_c, load_b, load_a} <= f_ld(cmd_dst);
            end else if (cmd_op != OP_SWAP) begin
              bus_sel                  <= cmd_dst;
              {load_c, load_b, load_a} <= f_ld(cmd_dst);
            end
            // A SWAP has no write in EXEC. Its first move is set up on the way into SW1.
          end
        end
        S_EXEC: begin
          if (r_illegal) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (r_op == OP_SWAP && !r_same) begin
            r_state <= S_SW1;
            bus_sel <= SEL_A;
            load_c  <= 1'b1;
          end else begin
            // A completed MOVE/INC/DEC, or a SWAP of a register with itself (a no-op).
            r_state <= S_FIN;
            done    <= 1'b1;
          end
        end
        S_SW1: begin
          r_state <= S_SW2;
          bus_sel <= SEL_B;
          load_a  <= 1'b1;
        end
        S_SW2: begin
          r_state <= S_SW3;
          bus_sel <= SEL_C;
          load_b  <= 1'b1;
        end
        S_SW3: begin
          r_state <= S_FIN;
          done    <= 1'b1;
        end
        S_FIN: begin
          r_state   <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Register file. Reset has priority, so a write that is in flight when rst
  // is sampled never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a <= '0;
      reg_b <= '0;
      reg_c <= '0;
    end else begin
      if (load_a) reg_a <= w_wdata;
      if (load_b) reg_b <= w_wdata;
      if (load_c) reg_c <= w_wdata;
    end
  end

`ifdef XFER_COUNT_EN
  // Saturating strobe counter. At most one strobe is high per cycle, so +1 is enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= 8'd0;
    end else if ((load_a || load_b || load_c) && xfer_cnt != 8'hFF) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_xfer_seq.sv
module tb_reg_xfer_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op, cmd_src, cmd_dst;
  logic [1:0] bus_sel;
  logic       load_a, load_b, load_c;
  logic [3:0] reg_a, reg_b, reg_c;
  logic       busy, done, err;
`ifdef XFER_COUNT_EN
  logic [7:0] xfer_cnt;
`endif

  int tests = 0;
  int fails = 0;

  reg_xfer_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .bus_sel(bus_sel),
    .load_a(load_a), .load_b(load_b), .load_c(load_c),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c),
    .busy(busy), .done(done), .err(err)
`ifdef XFER_COUNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Strobe and pulse monitor. It samples mid-cycle, away from the active edge.
  int ncyc = 0, n_la = 0, n_lb = 0, n_lc = 0, n_done = 0, n_err = 0, n_multi = 0;
  int lb_cyc = -1, done_cyc = -1;
  int h0 = -1, h1 = -1, h2 = -1;
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      if (int'(load_a) + int'(load_b) + int'(load_c) > 1) n_multi++;
      if (load_a) begin n_la++; h2 = h1; h1 = h0; h0 = 0; end
      if (load_b) begin n_lb++; h2 = h1; h1 = h0; h0 = 1; lb_cyc = ncyc; end
      if (load_c) begin n_lc++; h2 = h1; h1 = h0; h0 = 2; end
      if (done) begin n_done++; done_cyc = ncyc; end
      if (err) n_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command, then wait until ready returns. Reports the number of
  // cycles ready stayed low (capped at 20).
  task automatic run(input logic [1:0] op, input logic [1:0] src,
                     input logic [1:0] dst, output int cyc);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  int cyc, b_la, b_lb, b_lc, b_done, b_err, tot;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 2'b00; cmd_dst = 2'b00;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_reg_a", reg_a, 0);
    chk("rst_reg_b", reg_b, 0);
    chk("rst_reg_c", reg_c, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bus_sel", bus_sel, 0);
    chk("rst_loads", {load_a, load_b, load_c}, 0);

    // 1: MOVE zero->A, then INC A x3
    b_la = n_la; b_done = n_done; b_err = n_err;
    run(2'b00, 2'b11, 2'b00, cyc); chk("t1_move_ready_low", cyc, 2);
    chk("t1_move_a", reg_a, 0);
    for (int i = 0; i < 3; i++) begin
      run(2'b01, 2'b00, 2'b00, cyc);
      chk("t1_inc_ready_low", cyc, 2);
    end
    chk("t1_reg_a", reg_a, 3);
    chk("t1_load_a_count", n_la - b_la, 4);
    chk("t1_done_count", n_done - b_done, 4);

    // 2: DEC B from 0 wraps to F, INC B wraps back to 0
    run(2'b10, 2'b00, 2'b01, cyc); chk("t2_dec_b_wrap", reg_b, 4'hF);
    run(2'b01, 2'b00, 2'b01, cyc); chk("t2_inc_b_wrap", reg_b, 0);
    chk("t2_no_err", n_err - b_err, 0);

    // 3: build A=5, B=9, C=2, then SWAP A,B
    for (int i = 0; i < 2; i++) run(2'b01, 2'b00, 2'b00, cyc);    // A 3->5
    for (int i = 0; i < 7; i++) run(2'b10, 2'b00, 2'b01, cyc);    // B 0->9
    run(2'b00, 2'b11, 2'b10, cyc);                                // C <- 0
    for (int i = 0; i < 2; i++) run(2'b01, 2'b00, 2'b10, cyc);    // C 0->2
    chk("t3_pre_a", reg_a, 5);
    chk("t3_pre_b", reg_b, 9);
    chk("t3_pre_c", reg_c, 2);
    b_la = n_la; b_lb = n_lb; b_lc = n_lc;
    run(2'b11, 2'b00, 2'b01, cyc);
    chk("t3_swap_ready_low", cyc, 5);
    chk("t3_a", reg_a, 9);
    chk("t3_b", reg_b, 5);
    chk("t3_c", reg_c, 5);
    tot = (n_la - b_la) + (n_lb - b_lb) + (n_lc - b_lc);
    chk("t3_strobes", tot, 3);
    chk("t3_order_first_c", h2, 2);
    chk("t3_order_second_a", h1, 0);
    chk("t3_order_third_b", h0, 1);
    chk("t3_done_after_load_b", done_cyc - lb_cyc, 1);

    // 4: illegal commands raise err for one cycle and write nothing
    b_la = n_la; b_lb = n_lb; b_lc = n_lc; b_err = n_err; b_done = n_done;
    run(2'b00, 2'b00, 2'b11, cyc); chk("t4_move_dst11_ready", cyc, 1);
    run(2'b11, 2'b00, 2'b10, cyc); chk("t4_swap_ac_ready", cyc, 1);
    chk("t4_err_count", n_err - b_err, 2);
    tot = (n_la - b_la) + (n_lb - b_lb) + (n_lc - b_lc);
    chk("t4_no_loads", tot, 0);
    chk("t4_no_done", n_done - b_done, 0);
    chk("t4_a", reg_a, 9);
    chk("t4_b", reg_b, 5);
    chk("t4_c", reg_c, 5);
    // A SWAP of a register with itself writes nothing but still completes.
    run(2'b11, 2'b01, 2'b01, cyc); chk("t4_swap_same_ready", cyc, 2);
    tot = (n_la - b_la) + (n_lb - b_lb) + (n_lc - b_lc);
    chk("t4_swap_same_no_loads", tot, 0);
    chk("t4_swap_same_done", n_done - b_done, 1);
    chk("t4_multi_strobe", n_multi, 0);

    // 5: reset asserted during SW2 of a SWAP
    cmd_op = 2'b11; cmd_src = 2'b00; cmd_dst = 2'b01; cmd_valid = 1'b1;
    tick();                    // accept, EXEC
    cmd_valid = 1'b0;
    tick();                    // SW1
    tick();                    // SW2
    chk("t5_in_sw2_load_a", load_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_a", reg_a, 0);
    chk("t5_b", reg_b, 0);
    chk("t5_c", reg_c, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_busy", busy, 0);
    b_la = n_la; b_lb = n_lb; b_lc = n_lc;
    for (int i = 0; i < 6; i++) tick();
    tot = (n_la - b_la) + (n_lb - b_lb) + (n_lc - b_lc);
    chk("t5_no_more_loads", tot, 0);

`ifdef XFER_COUNT_EN
    // 6: strobe counter saturates at 255
    chk("t6_cnt_reset", xfer_cnt, 0);
    for (int i = 0; i < 300; i++) run(2'b01, 2'b00, 2'b00, cyc);
    chk("t6_cnt_sat", xfer_cnt, 255);
    chk("t6_reg_a", reg_a, 4'(300));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
